// File: rtl/gsm_uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gsm_uart_pkg
// Purpose  : Shared types, constants and helpers for the GSM UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package gsm_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gsm_uart_baud_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gsm_uart_baud_cnt
// Purpose  : Loadable bit-period down-counter; bit_end marks the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module gsm_uart_baud_cnt #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic bit_end
);

    localparam int c_width = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_width-1:0] c_reload = c_width'(DIV - 1);

    logic [c_width-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_reload;
        end else if (run) begin
            if (r_cnt == '0) begin
                r_cnt <= c_reload;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bit_end = run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/gsm_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gsm_uart_tx
// Purpose  : 8N1 serial transmitter, one byte per rising edge of tx_enable.
//            Define GSM_UART_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module gsm_uart_tx
    import gsm_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DIV    = baud_div(CLK_HZ, BAUD)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_enable,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      txd,
    output logic                      tx_done,
    output logic                      tx_busy
);

    if (DIV < 2) begin : g_div_check
        $error("gsm_uart_tx: DIV must be >= 2");
    end

    localparam logic [2:0] c_last_bit = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state;
    logic                      r_en_q;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [2:0]                r_bit_idx;
    logic                      r_txd;
    logic                      r_done;
    logic                      r_busy;
`ifdef GSM_UART_PARITY_EN
    logic                      r_parity;
`endif

    logic w_accept;
    logic w_bit_end;

    assign w_accept = tx_enable && !r_en_q && (r_state == IDLE);

    gsm_uart_baud_cnt #(
        .DIV(DIV)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .run    (r_state != IDLE),
        .bit_end(w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en_q    <= 1'b1;  // a level held through reset must not fire
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef GSM_UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_en_q <= tx_enable;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= tx_data;
                        r_bit_idx <= '0;
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
`ifdef GSM_UART_PARITY_EN
                        r_parity  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_txd   <= r_shreg[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_last_bit) begin
`ifdef GSM_UART_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shreg   <= {1'b0, r_shreg[UART_DATA_BITS-1:1]};
                            r_txd     <= r_shreg[1];
                        end
                    end
                end
`ifdef GSM_UART_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_txd   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign txd     = r_txd;
    assign tx_done = r_done;
    assign tx_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gsm_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gsm_uart_tx
// Purpose  : Self-checking bench for gsm_uart_tx (frame-level reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsm_uart_tx;

    localparam int DIV = 10;
`ifdef GSM_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_enable = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       txd;
    logic       tx_done;
    logic       tx_busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_bytes[$];

    gsm_uart_tx #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_enable(tx_enable),
        .tx_data  (tx_data),
        .txd      (txd),
        .tx_done  (tx_done),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Whole frame as a bit vector, index = bit slot in time order.
    function automatic logic [10:0] build_frame(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef GSM_UART_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Reference model: frame position counter since acceptance.
    bit          m_active = 1'b0;
    int          m_t = 0;
    bit          m_enq = 1'b1;
    bit          m_done = 1'b0;
    logic [10:0] m_frame = '1;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_enq    = 1'b1;
            m_done   = 1'b0;
        end else begin
            bit req;
            req    = tx_enable && !m_enq;
            m_enq  = tx_enable;
            m_done = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == FL) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (req) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frame  = build_frame(tx_data);
            end
        end
    end

    // Per-cycle compare plus an independent line decoder.
    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;
    logic       prev_txd = 1'b1;

    always @(posedge clk) begin
        #1;
        chk("txd", int'(txd), m_active ? int'(m_frame[m_t / DIV]) : 1);
        chk("tx_done", int'(tx_done), int'(m_done));
        chk("tx_busy", int'(tx_busy), int'(m_active));

        if (rst) begin
            dec_active = 1'b0;
        end else if (!dec_active && prev_txd && !txd) begin
            dec_active = 1'b1;
            dec_cnt    = 0;
        end else if (dec_active) begin
            dec_cnt++;
            if (dec_cnt % DIV == DIV / 2) begin
                int b;
                b = dec_cnt / DIV;
                if (b >= 1 && b <= 8) dec_byte[b-1] = txd;
`ifdef GSM_UART_PARITY_EN
                if (b == 9) chk("parity_bit", int'(txd), int'(^dec_byte));
`endif
                if (b == NB - 1) begin
                    chk("stop_bit", int'(txd), 1);
                    if (exp_bytes.size() == 0) begin
                        chk("unexpected_frame", int'(dec_byte), -1);
                    end else begin
                        chk("decoded_byte", int'(dec_byte), int'(exp_bytes.pop_front()));
                    end
                    dec_active = 1'b0;
                end
            end
        end
        prev_txd = txd;
    end

    // Frame with hand-computed line pattern.
    task automatic lit_frame(input logic [7:0] d, input logic [10:0] exp_bits);
        int dones = 0;
        @(negedge clk);
        tx_enable = 1'b1;
        tx_data   = d;
        exp_bytes.push_back(d);
        for (int c = 0; c <= FL + 2; c++) begin
            @(negedge clk);
            if (tx_done) dones++;
            if (c % DIV == DIV / 2) chk("lit_bit", int'(txd), int'(exp_bits[c / DIV]));
            if (c == 0) chk("lit_busy_start", int'(tx_busy), 1);
            if (c == FL - 1) begin
                chk("lit_done_early", int'(tx_done), 0);
                chk("lit_busy_end", int'(tx_busy), 1);
            end
            if (c == FL) begin
                chk("lit_done", int'(tx_done), 1);
                chk("lit_busy_clear", int'(tx_busy), 0);
                tx_enable = 1'b0;
            end
        end
        chk("lit_done_count", dones, 1);
    endtask

    // Sequencer-style send: hold until tx_done, optional early drop / spurious re-rise.
    task automatic send_byte(input logic [7:0] d, input int drop_at, input bit spur);
        bit got = 1'b0;
        @(negedge clk);
        tx_enable = 1'b1;
        tx_data   = d;
        exp_bytes.push_back(d);
        for (int c = 0; c < FL + 20 && !got; c++) begin
            @(negedge clk);
            if (tx_done) begin
                got       = 1'b1;
                tx_enable = 1'b0;
            end else begin
                if (drop_at != 0 && c == drop_at) tx_enable = 1'b0;
                if (spur && c == drop_at + 3) begin
                    tx_enable = 1'b1;
                    tx_data   = 8'($urandom);
                end
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] d;
        int dones;

        repeat (3) @(negedge clk);
        chk("reset_txd", int'(txd), 1);
        chk("reset_done", int'(tx_done), 0);
        chk("reset_busy", int'(tx_busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef GSM_UART_PARITY_EN
        lit_frame(8'h41, 11'b100_1000_0010);
        lit_frame(8'h40, 11'b110_1000_0000);
`else
        lit_frame(8'h41, 11'b010_1000_0010);
        lit_frame(8'h40, 11'b010_1000_0000);
`endif

        // Rising edge while busy is ignored; no retrigger after tx_done.
        @(negedge clk);
        tx_enable = 1'b1;
        tx_data   = 8'h41;
        exp_bytes.push_back(8'h41);
        dones = 0;
        for (int c = 0; c <= FL + 5; c++) begin
            @(negedge clk);
            if (tx_done) dones++;
            if (c == 19) tx_enable = 1'b0;
            if (c == 34) begin
                tx_enable = 1'b1;
                tx_data   = 8'hFF;
            end
            if (c >= FL + 1) chk("post_idle_txd", int'(txd), 1);
        end
        chk("ignore_done_count", dones, 1);
        tx_enable = 1'b0;
        repeat (3) @(negedge clk);

        // Enable held high through reset must not start a frame.
        rst = 1'b1;
        @(negedge clk);
        tx_enable = 1'b1;
        tx_data   = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 29) begin
                chk("held_txd", int'(txd), 1);
                chk("held_busy", int'(tx_busy), 0);
            end
        end
        tx_enable = 1'b0;
        send_byte(8'hC3, 0, 1'b0);

        // Reset mid-frame aborts; a later request sends a full frame.
        @(negedge clk);
        tx_enable = 1'b1;
        tx_data   = 8'($urandom);
        for (int c = 0; c <= 52; c++) begin
            @(negedge clk);
            if (c == 46) rst = 1'b1;
            if (c == 47) begin
                rst = 1'b0;
                chk("midrst_txd", int'(txd), 1);
                chk("midrst_busy", int'(tx_busy), 0);
                chk("midrst_done", int'(tx_done), 0);
            end
            if (c == 52) tx_enable = 1'b0;
        end
        send_byte(8'h5A, 0, 1'b0);

        // Back-to-back AT-style characters.
        send_byte(8'h41, 0, 1'b0);
        send_byte(8'h54, 0, 1'b0);
        send_byte(8'h0D, 0, 1'b0);
        send_byte(8'h0A, 0, 1'b0);

        // Randomized bytes, gaps, early drops and spurious edges.
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(d, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, FL - 20)) : 0,
                      $urandom_range(0, 1) != 0);
        end

        repeat (FL) @(negedge clk);
        chk("pending_frames", exp_bytes.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
